mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 32 +++
 rtl/mem_lane_extract.sv | 29 ++
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional fault checking is enabled with MEM_RESP_ERR_EN.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_resp_state_t;

  // Low address bits that must be zero for an aligned access.
  function automatic logic [2:0] align_mask(mem_size_t sz);
    logic [2:0] m;
    m = 3'b000;
    unique case (sz)
      SZ_B: m = 3'b000;
      SZ_H: m = 3'b001;
      SZ_W: m = 3'b011;
      SZ_D: m = 3'b111;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Pulls a byte/half/word/double out of a 64-bit word
// and sign- or zero-extends it to 64 bits.
module mem_lane_extract
  import mem_resp_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [2:0]  lane_i,
  input  mem_size_t   size_i,
  input  logic        uns_i,
  output logic [63:0] data_o
);

  logic [63:0] sh;

  assign sh = word_i >> {lane_i, 3'b000};

  // Truncate to the access size, then extend.
  always_comb begin
    data_o = sh;
    unique case (size_i)
      SZ_B: data_o = {{56{~uns_i & sh[7]}}, sh[7:0]};
      SZ_H: data_o = {{48{~uns_i & sh[15]}}, sh[15:0]};
      SZ_W: data_o = {{32{~uns_i & sh[31]}}, sh[31:0]};
      SZ_D: data_o = sh;
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Variable-latency data-memory responder for the load/store path.
// Define MEM_RESP_ERR_EN for alignment/range faults; else force-align and wrap.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] WS = 8'(WAIT_STATES);

  mem_resp_state_t   state_q;
  logic [7:0]        cnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  mem_size_t         size_q;
  logic              uns_q;
  logic [63:0]       wdata_q;
  logic              resp_valid_q;
  logic [63:0]       rdata_q;

  logic [63:0] mem_q [DEPTH];

  logic [ADDR_W-4:0] idx_full;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        amask;
  logic [2:0]        lane;
  logic              fault;
  logic [63:0]       rd_word;
  logic [63:0]       ld_data;
  logic [7:0]        bmask;
  logic [63:0]       bitmask;
  logic [63:0]       word_d;
  logic              fire;
  logic              we;

  assign idx_full = addr_q[ADDR_W-1:3];
  assign idx      = IDX_W'(32'(idx_full) % DEPTH);
  assign amask    = align_mask(size_q);

`ifdef MEM_RESP_ERR_EN
  logic err_q;
  assign lane  = addr_q[2:0];
  assign fault = (|(addr_q[2:0] & amask)) ||
                 (32'(idx_full) >= DEPTH);
  assign resp_err = err_q;
`else
  assign lane  = addr_q[2:0] & ~amask;
  assign fault = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign rd_word = mem_q[idx];

  mem_lane_extract u_extract (
    .word_i (rd_word),
    .lane_i (lane),
    .size_i (size_q),
    .uns_i  (uns_q),
    .data_o (ld_data)
  );

  // Byte-enable and merged store word for the addressed lanes.
  always_comb begin
    bmask = 8'h00;
    unique case (size_q)
      SZ_B: bmask = 8'h01;
      SZ_H: bmask = 8'h03;
      SZ_W: bmask = 8'h0F;
      SZ_D: bmask = 8'hFF;
      default: bmask = 8'hFF;
    endcase
    bmask = bmask << lane;
    bitmask = '0;
    for (int i = 0; i < 8; i++) begin
      bitmask[i*8 +: 8] = {8{bmask[i]}};
    end
    word_d = (rd_word & ~bitmask) |
             ((wdata_q << {lane, 3'b000}) & bitmask);
  end

  assign fire = (state_q == WAIT) && (cnt_q == 8'd0);
  assign we   = fire && wr_q && !fault && !reset;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
`ifdef MEM_RESP_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            size_q  <= mem_size_t'(req_size);
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            cnt_q   <= WS;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= (wr_q || fault) ? 64'd0 : ld_data;
`ifdef MEM_RESP_ERR_EN
            err_q        <= fault;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage array; merged word commits on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= word_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
// Covers timing, extension, byte merge, backpressure, faults and reset.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int checks;
  int errors;

  logic [63:0] rd;
  logic        er;
  int          lat;
  logic [63:0] snap;

  mem_responder #(
    .DEPTH(64), .ADDR_W(16), .WAIT_STATES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for acceptance, then drain the response.
  task automatic do_req(input logic w, input logic [15:0] a,
                        input logic [1:0] sz, input logic u,
                        input logic [63:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_size = sz;
    req_unsigned = u;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = 16'hFFFF;
    req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
    lat = 0;
    rd = '0;
    er = 1'b0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid) break;
    end
    if (!resp_valid) check("resp_timeout", 64'd1, 64'd0);
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_wdata = '0;
    resp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_req_ready", 64'(req_ready), 64'd1);

    do_req(1'b1, 16'h0010, 2'd3, 1'b0, 64'h1122334455667788);
    check("st_d_lat", 64'(lat), 64'd3);
    check("st_d_rdata", rd, 64'd0);
    check("st_d_err", 64'(er), 64'd0);

    do_req(1'b0, 16'h0010, 2'd3, 1'b1, 64'd0);
    check("ld_d_lat", 64'(lat), 64'd3);
    check("ld_d_data", rd, 64'h1122334455667788);

    do_req(1'b0, 16'h0017, 2'd0, 1'b0, 64'd0);
    check("ld_b_pos", rd, 64'h11);
    do_req(1'b0, 16'h0012, 2'd1, 1'b0, 64'd0);
    check("ld_h_lane2", rd, 64'h5566);

    do_req(1'b1, 16'h0017, 2'd0, 1'b0, 64'hFF);
    do_req(1'b0, 16'h0017, 2'd0, 1'b0, 64'd0);
    check("ld_b_sext", rd, 64'hFFFFFFFFFFFFFFFF);
    do_req(1'b0, 16'h0017, 2'd0, 1'b1, 64'd0);
    check("ld_b_zext", rd, 64'h00000000000000FF);
    do_req(1'b0, 16'h0010, 2'd3, 1'b0, 64'd0);
    check("st_b_merge", rd, 64'hFF22334455667788);
    do_req(1'b0, 16'h0014, 2'd2, 1'b0, 64'd0);
    check("ld_w_sext", rd, 64'hFFFFFFFFFF223344);

    // Backpressure: hold resp_ready low with a competing request.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 16'h0010;
    req_size = 2'd3;
    req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    req_addr = 16'h0018;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd3);
    snap = resp_rdata;
    check("bp_data", snap, 64'hFF22334455667788);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid_hold", 64'(resp_valid), 64'd1);
      check("bp_rdata_hold", resp_rdata, 64'hFF22334455667788);
      check("bp_no_accept", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("bp_valid_clr", 64'(resp_valid), 64'd0);
    check("bp_ready_back", 64'(req_ready), 64'd1);

`ifdef MEM_RESP_ERR_EN
    do_req(1'b1, 16'h0013, 2'd1, 1'b0, 64'hABCD);
    check("err_mis_st", 64'(er), 64'd1);
    check("err_mis_lat", 64'(lat), 64'd3);
    do_req(1'b0, 16'h0010, 2'd3, 1'b0, 64'd0);
    check("err_mem_kept", rd, 64'hFF22334455667788);
    check("err_ok_clr", 64'(er), 64'd0);
    do_req(1'b0, 16'h0200, 2'd3, 1'b0, 64'd0);
    check("err_range", 64'(er), 64'd1);
    check("err_range_rd", rd, 64'd0);
`else
    do_req(1'b0, 16'h0015, 2'd2, 1'b1, 64'd0);
    check("fa_w_data", rd, 64'h00000000FF223344);
    check("fa_w_err", 64'(er), 64'd0);
    do_req(1'b0, 16'h0210, 2'd3, 1'b0, 64'd0);
    check("wrap_d_data", rd, 64'hFF22334455667788);
    check("wrap_d_err", 64'(er), 64'd0);
`endif

    // Reset one cycle after accepting a store abandons it.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 16'h0010;
    req_size = 2'd3;
    req_wdata = 64'hCAFEF00DCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst2_ready_low", 64'(req_ready), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_valid", 64'(resp_valid), 64'd0);
    check("rst2_ready", 64'(req_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("rst2_no_resp", 64'(resp_valid), 64'd0);
    do_req(1'b0, 16'h0010, 2'd3, 1'b0, 64'd0);
    check("rst2_mem_kept", rd, 64'hFF22334455667788);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
